// File: rtl/invaders_pkg.sv
// Shared constants and encodings for the invaders interrupt path.
// Opcodes are the i8080 RST 1 / RST 2 single-byte instructions.
package invaders_pkg;

    localparam logic [7:0] OPC_RST1    = 8'hCF;
    localparam logic [7:0] OPC_RST2    = 8'hD7;
    localparam int         STATUS_INTA = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

    typedef enum logic {
        SEL_MID = 1'b0,
        SEL_VBL = 1'b1
    } ack_sel_t;

    function automatic logic [7:0] rst_opcode(input ack_sel_t sel);
        return (sel == SEL_VBL) ? OPC_RST2 : OPC_RST1;
    endfunction

endpackage

// File: rtl/irq_scheduler_if.sv
// CPU-side interrupt handshake: enable, status strobe, read strobe and request.
// No latency of its own; the CPU never stalls the scheduler.
interface irq_scheduler_if;

    logic inte;
    logic sync;
    logic dbin;
    logic iint;

    modport master (output inte, output sync, output dbin, input  iint);
    modport slave  (input  inte, input  sync, input  dbin, output iint);

endinterface

// File: rtl/frame_timer.sv
// Scanline/frame counters with vblank and line-start post strobes.
// Strobes are combinational from the counters; free-running, no backpressure.
module frame_timer #(
    parameter int CLKS_PER_LINE   = 64,
    parameter int LINES_PER_FRAME = 262,
    parameter int MID_LINE        = 96,
    parameter int VBL_LINE        = 224,
    parameter int LINE_W          = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LINE_W-1:0] line,
    output logic              vblank,
    output logic              mid_post,
    output logic              vbl_post
);

    localparam int                HCNT_W    = $clog2(CLKS_PER_LINE);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(CLKS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [LINE_W-1:0] MID_L     = LINE_W'(MID_LINE);
    localparam logic [LINE_W-1:0] VBL_L     = LINE_W'(VBL_LINE);

    logic [HCNT_W-1:0] hcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            line <= '0;
        end else if (hcnt == HCNT_LAST) begin
            hcnt <= '0;
            line <= (line == LINE_LAST) ? '0 : line + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign vblank   = (line >= VBL_L);
    assign mid_post = (hcnt == '0) && (line == MID_L);
    assign vbl_post = (hcnt == '0) && (line == VBL_L);

endmodule

// File: rtl/irq_scheduler.sv
// Posts RST 1/RST 2 requests from frame timing and answers INTA with the opcode.
// iint one clk after a post; bus driven only in ACK while dbin is high.
module irq_scheduler
    import invaders_pkg::*;
#(
    parameter int CLKS_PER_LINE   = 64,
    parameter int LINES_PER_FRAME = 262,
    parameter int MID_LINE        = 96,
    parameter int VBL_LINE        = 224,
    parameter int LINE_W          = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_scheduler_if.slave    cpu,
    inout  wire  [7:0]        data,
    output logic [LINE_W-1:0] line,
    output logic              vblank,
    output logic              missed
);

    logic       mid_post, vbl_post;
    logic       pend_mid, pend_vbl, pend_mid_nxt, pend_vbl_nxt;
    logic       clr_mid, clr_vbl, ack_done, dbin_q;
    ack_state_t state, state_nxt;
    ack_sel_t   ack_sel, ack_sel_nxt;

    frame_timer #(
        .CLKS_PER_LINE  (CLKS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME),
        .MID_LINE       (MID_LINE),
        .VBL_LINE       (VBL_LINE),
        .LINE_W         (LINE_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .line    (line),
        .vblank  (vblank),
        .mid_post(mid_post),
        .vbl_post(vbl_post)
    );

    always_comb begin
        state_nxt   = state;
        ack_sel_nxt = ack_sel;
        ack_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu.sync && data[STATUS_INTA] && (pend_mid || pend_vbl)) begin
                    state_nxt   = ST_ACK;
                    ack_sel_nxt = pend_vbl ? SEL_VBL : SEL_MID;
                end
            end
            ST_ACK: begin
                // Completed read takes precedence over an abort in the same clk.
                if (dbin_q && !cpu.dbin) begin
                    ack_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cpu.sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A post in the clearing clk re-arms the flag and is not counted as missed.
    assign clr_mid      = ack_done && (ack_sel == SEL_MID);
    assign clr_vbl      = ack_done && (ack_sel == SEL_VBL);
    assign pend_mid_nxt = mid_post | (pend_mid & ~clr_mid);
    assign pend_vbl_nxt = vbl_post | (pend_vbl & ~clr_vbl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ack_sel  <= SEL_MID;
            dbin_q   <= 1'b0;
            pend_mid <= 1'b0;
            pend_vbl <= 1'b0;
            missed   <= 1'b0;
            cpu.iint <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_sel  <= ack_sel_nxt;
            dbin_q   <= (state_nxt == ST_ACK) && cpu.dbin;
            pend_mid <= pend_mid_nxt;
            pend_vbl <= pend_vbl_nxt;
            missed   <= (mid_post && pend_mid && !clr_mid) ||
                        (vbl_post && pend_vbl && !clr_vbl);
            cpu.iint <= cpu.inte && (pend_mid_nxt || pend_vbl_nxt);
        end
    end

    assign data = (state == ST_ACK && cpu.dbin) ? rst_opcode(ack_sel) : 8'hzz;

endmodule

// File: doc/irq_scheduler.md
Name: irq_scheduler

Overview:
Frame-timing interrupt scheduler for the invaders system. Counts clocks into scanlines and frames, raises the mid-screen (RST 1) and vblank (RST 2) interrupt requests, and drives the i8080 `iint` input. During the CPU's interrupt-acknowledge machine cycle it supplies the RST opcode on the shared tri-state data bus, alongside the ROM and RAM.

Parameters:
CLKS_PER_LINE, 64, clocks per scanline; must be >= 2
LINES_PER_FRAME, 262, scanlines per frame; must be > VBL_LINE
MID_LINE, 96, line whose first clock posts the RST 1 request
VBL_LINE, 224, line whose first clock posts the RST 2 request; must differ from MID_LINE
LINE_W, 9, width of the line counter; must satisfy 2^LINE_W >= LINES_PER_FRAME

Ports:
clk  input  1  system clock; the only clock
rst_n  input  1  reset; asynchronous assert, active-low
inte  input  1  CPU interrupt-enable flag
sync  input  1  CPU status strobe; high for one clock at the start of each machine cycle
dbin  input  1  CPU data-bus-in strobe
data  inout  8  shared system data bus; status word sampled at sync, opcode driven at INTA
iint  output  1  interrupt request to the CPU
line  output  LINE_W  current scanline, 0..LINES_PER_FRAME-1
vblank  output  1  high when line >= VBL_LINE
missed  output  1  one-clock pulse when a request is posted while the same request is still pending

Behaviour:
- Reset (rst_n low, async):
  - hcnt=0, line=0.
  - pend_mid=0, pend_vbl=0, ack_active=0, ack_sel=0.
  - iint=0, missed=0, vblank=0.
  - data bus released (Z).
- Timing:
  - hcnt increments each clk and wraps at CLKS_PER_LINE-1 -> 0.
  - line increments when hcnt wraps, and wraps at LINES_PER_FRAME-1 -> 0.
  - vblank is combinational from line.
- Posting:
  - On the clock where hcnt==0 and line==MID_LINE, set pend_mid.
  - On the clock where hcnt==0 and line==VBL_LINE, set pend_vbl.
  - Posting an already-set pend flag leaves it set and pulses missed for one clk.
- Request: iint = inte & (pend_mid | pend_vbl), registered with one clk latency. Pending flags persist while inte=0.
- Acknowledge FSM, states IDLE -> ACK -> IDLE:
  - IDLE: on a clk edge with sync=1 and data[0]=1 (INTA status bit) and a flag pending:
    - go to ACK.
    - latch ack_sel = VBL if pend_vbl, else MID (vblank has priority).
    - if nothing is pending, stay in IDLE and never drive the bus.
  - ACK: drive data = 8'hD7 (RST 2) when ack_sel=VBL, else 8'hCF (RST 1), only while dbin=1 (combinational enable); Z otherwise.
  - ACK exits on the first clk with dbin=1 followed by dbin=0 (falling edge detected in a register):
    - clear the selected pend flag.
    - return to IDLE.
  - A new sync while in ACK (bus aborted) returns to IDLE without clearing any flag.
  - A post for the flag being acknowledged in the same clk as its clear: the post wins; the flag stays set and missed does not pulse.
- The bus is never driven outside ACK. The bus is driven by at most one source; ROM and RAM are not read during INTA because the CPU places no valid memory address.
- Reset mid-ACK releases the bus immediately (async).

Decomposition:
- Shared package `invaders_pkg`:
  - constants OPC_RST1=8'hCF, OPC_RST2=8'hD7.
  - status bit index STATUS_INTA=0.
  - ack FSM state encoding.
- One natural sub-module: `frame_timer` (hcnt/line counters, vblank, line-start strobes for MID/VBL). irq_scheduler instantiates it and keeps pending flags, FSM and bus drive.

Test Plan:
Bench parameters: CLKS_PER_LINE=4, LINES_PER_FRAME=8, MID_LINE=3, VBL_LINE=6, LINE_W=3.
- Reset then free-run 32 clks -> line sequence 0..7 repeating every 32 clks; vblank high exactly on lines 6,7; iint=0 while inte=0.
- inte=1, wait for line 3 -> iint rises 1 clk after hcnt==0 on line 3; sync with data=8'h23 (INTA set) then dbin pulse -> data reads 8'hCF during dbin; pend_mid cleared, iint low next clk.
- Same flow at line 6 -> data reads 8'hD7; with both flags pending (inte held 0 across lines 3 and 6, then raised) -> first ack returns D7, second ack returns CF.
- Never acknowledge for a full frame -> missed pulses exactly once at line 3 and once at line 6 of the second frame; flags remain set.
- sync with data[0]=0 (e.g. 8'hA2 memory read) while pending -> bus stays Z through dbin; flags unchanged.
- Assert rst_n=0 while in ACK with dbin=1 -> data goes Z asynchronously; after release all flags 0, line 0, iint 0.
